// File: rtl/capsense_pkg.sv
// Shared definitions for capsense_events: event type codes, per-button FSM states
// and the button-index width helper.
package capsense_pkg;

   typedef enum logic [1:0] {
      EV_PRESS   = 2'd0,
      EV_RELEASE = 2'd1,
      EV_LONG    = 2'd2,
      EV_REPEAT  = 2'd3
   } ev_type_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HELD = 2'd1,
      ST_LONG = 2'd2
   } btn_state_e;

   // Width of the button index field: max(1, clog2(n)).
   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/capsense_ev_fifo.sv
// Synchronous event FIFO: push gated by full (push+pop while full is accepted),
// head presented over a valid/ready handshake. DEPTH must be a power of two.
module capsense_ev_fifo #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] data_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [AW:0]      cnt_q, cnt_d;
   logic             do_push;
   logic             do_pop;

   assign valid_o = (cnt_q != '0);
   assign full_o  = (cnt_q == (AW+1)'(DEPTH));
   assign do_pop  = valid_o && ready_i;
   assign do_push = push_i && (!full_o || do_pop);
   // Head is masked while empty so the output reads 0 without clearing the storage.
   assign data_o  = valid_o ? mem_q[rd_q] : '0;

   always_comb begin
      // NOTE: every next-state signal takes its current value first, so no path leaves it unassigned and no latch is inferred.
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;
      if (do_push) wr_d = wr_q + 1'b1;
      if (do_pop)  rd_d = rd_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   // NOTE: the storage array has no reset; pointers and count alone define which entries are live.
   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/capsense_events.sv
// Per-button debounce, PRESS/RELEASE/LONG event generation, pending slots, arbiter and event FIFO.
// Define CAPSENSE_REPEAT_EN to emit REPEAT events every REPEAT_MS while a button stays in LONG.
module capsense_events
   import capsense_pkg::*;
#(
   parameter int N          = 4,
   parameter int FREQUENCY  = 24,
   parameter int DEB_MS     = 100,
   parameter int LONG_MS    = 1000,
   parameter int REPEAT_MS  = 200,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [N-1:0]              buttons_i,
   output logic [N-1:0]              held_o,
   output logic                      ev_valid_o,
   input  logic                      ev_ready_i,
   output logic [idx_width(N)+1:0]   ev_code_o,
   output logic                      overflow_o,
   input  logic                      clr_ovf_i
);

   localparam int IB      = idx_width(N);
   localparam int CW      = IB + 2;
   localparam int PRE_MAX = FREQUENCY * 1000 - 1;
   localparam int PRE_W   = $clog2(PRE_MAX + 1);
   localparam int DEB_W   = $clog2(DEB_MS + 1);
   localparam int HOLD_W  = $clog2(LONG_MS + 1);
`ifdef CAPSENSE_REPEAT_EN
   localparam int REP_W   = $clog2(REPEAT_MS + 1);
`else
   logic rep_unused;
   assign rep_unused = (REPEAT_MS != 0);
`endif

   logic [PRE_W-1:0] pre_q, pre_d;
   logic             tick;
   logic [N-1:0]     held;
   logic [N-1:0]     slot_v;
   logic [2*N-1:0]   slot_t;
   logic [N-1:0]     grant;
   logic [N-1:0]     drop;
   logic             arb_found;
   logic             fifo_push;
   logic             fifo_full;
   logic             fifo_valid;
   logic             fifo_room;
   logic [CW-1:0]    push_code;
   logic             ovf_q, ovf_d;

   assign tick  = (pre_q == PRE_W'(PRE_MAX));
   assign pre_d = tick ? '0 : pre_q + 1'b1;
   assign ovf_d = (ovf_q && !clr_ovf_i) || (|drop);

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         pre_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         pre_q <= pre_d;
         ovf_q <= ovf_d;
      end
   end

   for (genvar gi = 0; gi < N; gi++) begin : g_btn
      btn_state_e        st_q, st_d;
      logic              held_q, held_d;
      logic [DEB_W-1:0]  deb_q, deb_d;
      logic [HOLD_W-1:0] hold_q, hold_d;
      logic              slot_v_q, slot_v_d;
      ev_type_e          slot_t_q, slot_t_d;
      logic              ev_raise;
      ev_type_e          ev_type;
      logic              drop_c;
`ifdef CAPSENSE_REPEAT_EN
      logic [REP_W-1:0]  rep_q, rep_d;
`endif

      always_comb begin
         st_d     = st_q;
         held_d   = held_q;
         deb_d    = deb_q;
         hold_d   = hold_q;
         slot_v_d = slot_v_q;
         slot_t_d = slot_t_q;
         ev_raise = 1'b0;
         ev_type  = EV_PRESS;
         drop_c   = 1'b0;
`ifdef CAPSENSE_REPEAT_EN
         rep_d    = rep_q;
`endif

         if (buttons_i[gi] == held_q) begin
            deb_d = '0;
         end else if (tick) begin
            if (deb_q == DEB_W'(DEB_MS - 1)) begin
               deb_d    = '0;
               held_d   = ~held_q;
               ev_raise = 1'b1;
               ev_type  = held_q ? EV_RELEASE : EV_PRESS;
            end else begin
               deb_d = deb_q + 1'b1;
            end
         end

         // A debounced edge outranks a LONG/REPEAT falling on the same tick.
         if (ev_raise && (ev_type == EV_PRESS)) begin
            st_d   = ST_HELD;
            hold_d = '0;
         end else if (ev_raise) begin
            st_d = ST_IDLE;
`ifdef CAPSENSE_REPEAT_EN
            rep_d = '0;
`endif
         end else if (tick && (st_q != ST_IDLE)) begin
            if (hold_q != HOLD_W'(LONG_MS)) hold_d = hold_q + 1'b1;
            if ((st_q == ST_HELD) && (hold_q == HOLD_W'(LONG_MS - 1))) begin
               st_d     = ST_LONG;
               ev_raise = 1'b1;
               ev_type  = EV_LONG;
            end
`ifdef CAPSENSE_REPEAT_EN
            else if (st_q == ST_LONG) begin
               if (rep_q == REP_W'(REPEAT_MS - 1)) begin
                  rep_d    = '0;
                  ev_raise = 1'b1;
                  ev_type  = EV_REPEAT;
               end else begin
                  rep_d = rep_q + 1'b1;
               end
            end
`endif
         end

         // A slot being granted this cycle is already leaving and may be refilled.
         if (grant[gi]) slot_v_d = 1'b0;
         if (ev_raise) begin
            if (!slot_v_q || grant[gi]) begin
               slot_v_d = 1'b1;
               slot_t_d = ev_type;
            end else begin
               drop_c = 1'b1;
            end
         end
      end

      always_ff @(posedge clk_i or negedge rst_i) begin
         if (!rst_i) begin
            st_q     <= ST_IDLE;
            held_q   <= 1'b0;
            deb_q    <= '0;
            hold_q   <= '0;
            slot_v_q <= 1'b0;
            slot_t_q <= EV_PRESS;
`ifdef CAPSENSE_REPEAT_EN
            rep_q    <= '0;
`endif
         end else begin
            st_q     <= st_d;
            held_q   <= held_d;
            deb_q    <= deb_d;
            hold_q   <= hold_d;
            slot_v_q <= slot_v_d;
            slot_t_q <= slot_t_d;
`ifdef CAPSENSE_REPEAT_EN
            rep_q    <= rep_d;
`endif
         end
      end

      assign held[gi]           = held_q;
      assign slot_v[gi]         = slot_v_q;
      assign slot_t[2*gi +: 2]  = slot_t_q;
      assign drop[gi]           = drop_c;
   end

   assign fifo_room = !fifo_full || (fifo_valid && ev_ready_i);

   // Fixed priority: the lowest-index pending slot wins the single FIFO push per cycle.
   always_comb begin
      grant     = '0;
      arb_found = 1'b0;
      push_code = '0;
      for (int i = 0; i < N; i++) begin
         if (!arb_found && slot_v[i]) begin
            arb_found = 1'b1;
            grant[i]  = fifo_room;
            push_code = {slot_t[2*i +: 2], IB'(i)};
         end
      end
      fifo_push = arb_found && fifo_room;
   end

   capsense_ev_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (fifo_push),
      .data_i  (push_code),
      .full_o  (fifo_full),
      .valid_o (fifo_valid),
      .ready_i (ev_ready_i),
      .data_o  (ev_code_o)
   );

   assign held_o     = held;
   assign ev_valid_o = fifo_valid;
   assign overflow_o = ovf_q;

endmodule

// File: tb/tb_capsense_events.sv
// Scoreboard bench for capsense_events (1 MHz, 1000-cycle ms tick, DEB 2 ms, LONG 10 ms, REPEAT 4 ms, FIFO 4).
`timescale 1ns/1ps
module tb_capsense_events;

   localparam int MS = 1000;
   localparam logic [1:0] T_PRESS = 2'd0;
   localparam logic [1:0] T_REL   = 2'd1;
   localparam logic [1:0] T_LONG  = 2'd2;
`ifdef CAPSENSE_REPEAT_EN
   localparam logic [1:0] T_REP   = 2'd3;
`endif

   logic       clk = 1'b0;
   logic       rst_i = 1'b0;
   logic [3:0] buttons_i = 4'b0000;
   logic [3:0] held_o;
   logic       ev_valid_o;
   logic       ev_ready_i = 1'b1;
   logic [3:0] ev_code_o;
   logic       overflow_o;
   logic       clr_ovf_i = 1'b0;

   int cyc   = 0;
   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [3:0] code;
      int         lo;
      int         hi;
   } exp_t;
   exp_t sb[$];

   capsense_events #(
      .N          (4),
      .FREQUENCY  (1),
      .DEB_MS     (2),
      .LONG_MS    (10),
      .REPEAT_MS  (4),
      .FIFO_DEPTH (4)
   ) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .buttons_i  (buttons_i),
      .held_o     (held_o),
      .ev_valid_o (ev_valid_o),
      .ev_ready_i (ev_ready_i),
      .ev_code_o  (ev_code_o),
      .overflow_o (overflow_o),
      .clr_ovf_i  (clr_ovf_i)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_win(input string name, input int act, input int lo, input int hi);
      n_vec++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: event at cycle %0d, expected within [%0d,%0d]", name, act, lo, hi);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Event due k ticks after an input edge driven at cycle edge_c.
   task automatic expect_ev(input logic [1:0] t, input logic [1:0] idx, input int edge_c, input int k);
      exp_t e;
      e.code = {t, idx};
      e.lo   = edge_c + (k - 1) * MS;
      e.hi   = edge_c + k * MS + 10;
      sb.push_back(e);
   endtask

   task automatic expect_any(input logic [1:0] t, input logic [1:0] idx);
      exp_t e;
      e.code = {t, idx};
      e.lo   = 0;
      e.hi   = 32'h7fff_ffff;
      sb.push_back(e);
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_i && ev_valid_o && ev_ready_i) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_event: got code 0x%0h, none expected (cycle %0d)", ev_code_o, cyc);
         end else begin
            e = sb.pop_front();
            check("ev_code", 32'(ev_code_o), 32'(e.code));
            check_win("ev_time", cyc, e.lo, e.hi);
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int e0;
      int e1;

      step(5);
      check("rst_held", 32'(held_o), 32'h0);
      check("rst_valid", 32'(ev_valid_o), 32'h0);
      check("rst_code", 32'(ev_code_o), 32'h0);
      check("rst_ovf", 32'(overflow_o), 32'h0);
      rst_i = 1'b1;
      step(10);

      // 1 ms touch on button 2 is shorter than the debounce window.
      buttons_i[2] = 1'b1;
      step(MS);
      buttons_i[2] = 1'b0;
      step(10);
      check("glitch_held", 32'(held_o), 32'h0);
      step(2500);
      check("glitch_held_late", 32'(held_o), 32'h0);

      // Short press on button 1: PRESS then RELEASE, no LONG.
      e0 = cyc;
      buttons_i[1] = 1'b1;
      expect_ev(T_PRESS, 2'd1, e0, 2);
      step(2 * MS + 100);
      check("short_held", 32'(held_o), 32'h2);
      step(3 * MS - 100);
      e1 = cyc;
      buttons_i[1] = 1'b0;
      expect_ev(T_REL, 2'd1, e1, 2);
      step(2 * MS + 100);
      check("short_released", 32'(held_o), 32'h0);
      step(500);

      // 15 ms hold on button 0: PRESS, LONG, (REPEAT), RELEASE.
      e0 = cyc;
      buttons_i[0] = 1'b1;
      expect_ev(T_PRESS, 2'd0, e0, 2);
      expect_ev(T_LONG, 2'd0, e0, 12);
`ifdef CAPSENSE_REPEAT_EN
      expect_ev(T_REP, 2'd0, e0, 16);
`endif
      step(12 * MS + 100);
      check("long_held", 32'(held_o), 32'h1);
      step(3 * MS - 100);
      e1 = cyc;
      buttons_i[0] = 1'b0;
      expect_ev(T_REL, 2'd0, e1, 2);
      step(2 * MS + 100);
      check("long_released", 32'(held_o), 32'h0);
      step(500);

      // Simultaneous rise on buttons 0 and 3: lower index is queued first.
      e0 = cyc;
      buttons_i = 4'b1001;
      expect_ev(T_PRESS, 2'd0, e0, 2);
      expect_ev(T_PRESS, 2'd3, e0, 2);
      step(4 * MS);
      check("dual_held", 32'(held_o), 32'h9);
      e1 = cyc;
      buttons_i = 4'b0000;
      expect_ev(T_REL, 2'd0, e1, 2);
      expect_ev(T_REL, 2'd3, e1, 2);
      step(2 * MS + 100);
      check("dual_released", 32'(held_o), 32'h0);
      step(500);

      // Consumer stalled: fill FIFO, park a RELEASE in slot 0, then collide on slot 0.
      ev_ready_i = 1'b0;
      buttons_i  = 4'b1111;
      expect_any(T_PRESS, 2'd0);
      expect_any(T_PRESS, 2'd1);
      expect_any(T_PRESS, 2'd2);
      expect_any(T_PRESS, 2'd3);
      expect_any(T_REL, 2'd0);
      step(2 * MS + 100);
      check("full_valid", 32'(ev_valid_o), 32'h1);
      check("full_head", 32'(ev_code_o), 32'h0);
      check("full_held", 32'(held_o), 32'hF);
      check("full_ovf", 32'(overflow_o), 32'h0);
      buttons_i[0] = 1'b0;
      step(2 * MS + 100);
      check("pending_held", 32'(held_o), 32'hE);
      check("pending_head", 32'(ev_code_o), 32'h0);
      check("pending_ovf", 32'(overflow_o), 32'h0);
      buttons_i[0] = 1'b1;
      step(2 * MS + 100);
      check("collide_held", 32'(held_o), 32'hF);
      check("collide_ovf", 32'(overflow_o), 32'h1);
      clr_ovf_i = 1'b1;
      step(1);
      clr_ovf_i = 1'b0;
      check("ovf_cleared", 32'(overflow_o), 32'h0);
      ev_ready_i = 1'b1;
      step(20);
      check("drain_sb", 32'(sb.size()), 32'h0);
      check("drain_valid", 32'(ev_valid_o), 32'h0);
      e0 = cyc;
      buttons_i = 4'b0000;
      expect_ev(T_REL, 2'd0, e0, 2);
      expect_ev(T_REL, 2'd1, e0, 2);
      expect_ev(T_REL, 2'd2, e0, 2);
      expect_ev(T_REL, 2'd3, e0, 2);
      step(2 * MS + 100);
      check("all_released", 32'(held_o), 32'h0);
      step(500);

      // Reset in the middle of LONG, button kept held through reset release.
      e0 = cyc;
      buttons_i[0] = 1'b1;
      expect_ev(T_PRESS, 2'd0, e0, 2);
      expect_ev(T_LONG, 2'd0, e0, 12);
      step(12 * MS + 500);
      check("prerst_sb", 32'(sb.size()), 32'h0);
      check("prerst_held", 32'(held_o), 32'h1);
      #3;
      rst_i = 1'b0;
      #1;
      check("midrst_held", 32'(held_o), 32'h0);
      check("midrst_valid", 32'(ev_valid_o), 32'h0);
      check("midrst_code", 32'(ev_code_o), 32'h0);
      check("midrst_ovf", 32'(overflow_o), 32'h0);
      step(5);
      rst_i = 1'b1;
      e0 = cyc;
      expect_ev(T_PRESS, 2'd0, e0, 2);
      step(3 * MS);
      check("postrst_held", 32'(held_o), 32'h1);
      e1 = cyc;
      buttons_i[0] = 1'b0;
      expect_ev(T_REL, 2'd0, e1, 2);
      step(2 * MS + 100);
      check("postrst_released", 32'(held_o), 32'h0);

      for (int i = 0; i < 200 && sb.size() != 0; i++) step(1);
      check("final_sb_empty", 32'(sb.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
